// File: rtl/tt_project_mux.sv
// Chip-level project selector: picks one of N_PROJ wrappers from synchronized control pads,
// sequences its enable and project reset, and muxes its output word back to the pads.
module tt_project_mux #(
   parameter int N_PROJ       = 32,
   parameter int ADDR_W       = 5,
   parameter int RST_CYCLES   = 4,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   ctrl_sel_rst_n,
   input  logic                   ctrl_sel_inc,
   input  logic                   ctrl_ena,
   input  logic                   pad_clk,
   input  logic                   pad_rst_n,
   input  logic [7:0]             pad_ui_in,
   input  logic [7:0]             pad_uio_in,
   output logic [N_PROJ-1:0]      ena_bus,
   output logic [N_PROJ*18-1:0]   iw_bus,
   input  logic [N_PROJ*24-1:0]   ow_bus,
   output logic [7:0]             pad_uo_out,
   output logic [7:0]             pad_uio_out,
   output logic [7:0]             pad_uio_oe,
   output logic [ADDR_W-1:0]      cur_addr,
   output logic                   sel_active
);

   localparam int CNT_MAX = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0]  RST_LOAD   = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]  GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_PROJ - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_GUARD
   } state_t;

   logic [1:0]        sel_rst_sync_q;
   logic [1:0]        inc_sync_q;
   logic [1:0]        ena_sync_q;
   logic              inc_dly_q;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   state_t            state_q, state_d;
   logic [N_PROJ-1:0] ena_q, ena_d;

   logic s_sel_rst_n, s_inc, s_ena;
   logic inc_pulse, addr_chg, active_d, prst;
   logic [23:0] sel_ow;

   assign s_sel_rst_n = sel_rst_sync_q[1];
   assign s_inc       = inc_sync_q[1];
   assign s_ena       = ena_sync_q[1];
   assign inc_pulse   = s_inc & ~inc_dly_q;

   // The select-reset synchronizer idles high so a chip reset never looks like an address clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_rst_sync_q <= 2'b11;
         inc_sync_q     <= 2'b00;
         ena_sync_q     <= 2'b00;
         inc_dly_q      <= 1'b0;
         addr_q         <= '0;
         cnt_q          <= '0;
         state_q        <= ST_IDLE;
         ena_q          <= '0;
      end else begin
         sel_rst_sync_q <= {sel_rst_sync_q[0], ctrl_sel_rst_n};
         inc_sync_q     <= {inc_sync_q[0], ctrl_sel_inc};
         ena_sync_q     <= {ena_sync_q[0], ctrl_ena};
         inc_dly_q      <= s_inc;
         addr_q         <= addr_d;
         cnt_q          <= cnt_d;
         state_q        <= state_d;
         ena_q          <= ena_d;
      end
   end

   always_comb begin
      addr_d = addr_q;
      if (!s_sel_rst_n) begin
         addr_d = '0;
      end else if (inc_pulse) begin
         addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
      end
   end

   assign addr_chg = (addr_d != addr_q);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (s_ena) begin
               state_d = ST_RESET;
               cnt_d   = RST_LOAD;
            end
         end
         ST_RESET: begin
            if (!s_ena || addr_chg) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
            end else if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RUN: begin
            if (!s_ena || addr_chg) begin
               state_d = ST_GUARD;
               cnt_d   = GUARD_LOAD;
            end
         end
         ST_GUARD: begin
            // Any further address change restarts the full deselect interval.
            if (addr_chg) begin
               cnt_d = GUARD_LOAD;
            end else if (cnt_q == '0) begin
               if (s_ena) begin
                  state_d = ST_RESET;
                  cnt_d   = RST_LOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Enables are registered from next-state so they drop on the same edge the address moves.
   assign active_d = (state_d == ST_RESET) || (state_d == ST_RUN);

   always_comb begin
      ena_d = '0;
      for (int p = 0; p < N_PROJ; p++) begin
         ena_d[p] = active_d && (addr_d == ADDR_W'(p));
      end
   end

   assign prst = (state_q == ST_RUN) ? pad_rst_n : 1'b0;

   always_comb begin
      iw_bus = '0;
      sel_ow = '0;
      for (int p = 0; p < N_PROJ; p++) begin
         if (ena_q[p]) begin
            iw_bus[p*18 +: 18] = {pad_uio_in, pad_ui_in, prst, pad_clk};
            sel_ow             = ow_bus[p*24 +: 24];
         end
      end
   end

   assign {pad_uio_oe, pad_uio_out, pad_uo_out} = sel_ow;
   assign ena_bus    = ena_q;
   assign cur_addr   = addr_q;
   assign sel_active = (state_q == ST_RESET) || (state_q == ST_RUN);

endmodule

// File: tb/tb_tt_project_mux.sv
// Bench for tt_project_mux: directed scenarios plus randomized pad activity, checked every
// cycle against a cycle-level behavioural model of the selection rules.
module tb_tt_project_mux;

   localparam int N  = 32;
   localparam int AW = 5;
   localparam int RC = 4;
   localparam int GC = 2;
   localparam int N2 = 24;

   localparam int P_IDLE = 0;
   localparam int P_RST  = 1;
   localparam int P_RUN  = 2;
   localparam int P_GRD  = 3;

   logic clk = 1'b0;
   logic rst_n;
   logic ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena;
   logic pad_clk, pad_rst_n;
   logic [7:0] pad_ui_in, pad_uio_in;

   logic [N-1:0]    ena_bus;
   logic [N*18-1:0] iw_bus;
   logic [N*24-1:0] ow_bus;
   logic [7:0]      pad_uo_out, pad_uio_out, pad_uio_oe;
   logic [AW-1:0]   cur_addr;
   logic            sel_active;

   logic [N2-1:0]    ena24;
   logic [N2*18-1:0] iw24;
   logic [N2*24-1:0] ow24;
   logic [7:0]       uo24, uio24, oe24;
   logic [AW-1:0]    addr24;
   logic             act24;

   int n_assert = 0;
   int n_fail   = 0;

   tt_project_mux #(.N_PROJ(N), .ADDR_W(AW), .RST_CYCLES(RC), .GUARD_CYCLES(GC)) dut (
      .clk(clk), .rst_n(rst_n),
      .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
      .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
      .ena_bus(ena_bus), .iw_bus(iw_bus), .ow_bus(ow_bus),
      .pad_uo_out(pad_uo_out), .pad_uio_out(pad_uio_out), .pad_uio_oe(pad_uio_oe),
      .cur_addr(cur_addr), .sel_active(sel_active)
   );

   tt_project_mux #(.N_PROJ(N2), .ADDR_W(AW), .RST_CYCLES(RC), .GUARD_CYCLES(GC)) dut24 (
      .clk(clk), .rst_n(rst_n),
      .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
      .pad_clk(pad_clk), .pad_rst_n(pad_rst_n), .pad_ui_in(pad_ui_in), .pad_uio_in(pad_uio_in),
      .ena_bus(ena24), .iw_bus(iw24), .ow_bus(ow24),
      .pad_uo_out(uo24), .pad_uio_out(uio24), .pad_uio_oe(oe24),
      .cur_addr(addr24), .sel_active(act24)
   );

   always #5 clk = ~clk;

   // Behavioural model: pad history, address as an integer, phase plus cycles-left count.
   logic [1:0] m_sr = 2'b11, m_inc = 2'b00, m_en = 2'b00;
   logic m_incd = 1'b0;
   int   m_addr = 0, m_addr24 = 0, m_phase = P_IDLE, m_left = 0;
   int   na, na24;
   logic pulse, chg, s_sr, s_inc, s_en;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_sr = 2'b11; m_inc = 2'b00; m_en = 2'b00; m_incd = 1'b0;
         m_addr = 0; m_addr24 = 0; m_phase = P_IDLE; m_left = 0;
      end else begin
         s_sr  = m_sr[1];
         s_inc = m_inc[1];
         s_en  = m_en[1];
         pulse = s_inc && !m_incd;
         m_incd = s_inc;
         na   = !s_sr ? 0 : (pulse ? (m_addr + 1) % N : m_addr);
         na24 = !s_sr ? 0 : (pulse ? (m_addr24 + 1) % N2 : m_addr24);
         chg  = (na != m_addr);
         case (m_phase)
            P_IDLE: if (s_en) begin m_phase = P_RST; m_left = RC; end
            P_RST: begin
               if (!s_en || chg) begin m_phase = P_GRD; m_left = GC; end
               else begin
                  m_left--;
                  if (m_left == 0) m_phase = P_RUN;
               end
            end
            P_RUN: if (!s_en || chg) begin m_phase = P_GRD; m_left = GC; end
            default: begin
               if (chg) m_left = GC;
               else begin
                  m_left--;
                  if (m_left == 0) begin
                     if (s_en) begin m_phase = P_RST; m_left = RC; end
                     else m_phase = P_IDLE;
                  end
               end
            end
         endcase
         m_addr   = na;
         m_addr24 = na24;
         m_sr  = {m_sr[0], ctrl_sel_rst_n};
         m_inc = {m_inc[0], ctrl_sel_inc};
         m_en  = {m_en[0], ctrl_ena};
      end
   end

   task automatic chk(input string tag, input logic [N*24-1:0] obs, input logic [N*24-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic [N-1:0]    e_ena;
      logic [N*18-1:0] e_iw;
      logic [23:0]     e_ow;
      logic            act;
      logic [AW-1:0]   a, a24;
      act  = (m_phase == P_RST) || (m_phase == P_RUN);
      e_ena = '0;
      e_iw  = '0;
      e_ow  = '0;
      if (act) begin
         e_ena[m_addr] = 1'b1;
         e_iw[m_addr*18 +: 18] = {pad_uio_in, pad_ui_in, (m_phase == P_RUN) ? pad_rst_n : 1'b0, pad_clk};
         e_ow = ow_bus[m_addr*24 +: 24];
      end
      a   = m_addr[AW-1:0];
      a24 = m_addr24[AW-1:0];
      chk("m_ena_bus", ena_bus, e_ena);
      chk("m_iw_bus", iw_bus, e_iw);
      chk("m_pad_out", {pad_uio_oe, pad_uio_out, pad_uo_out}, e_ow);
      chk("m_cur_addr", cur_addr, a);
      chk("m_sel_active", sel_active, act);
      chk("m_cur_addr24", addr24, a24);
   endtask

   task automatic tick();
      @(negedge clk);
      check_model();
   endtask

   task automatic inc_pulse();
      ctrl_sel_inc = 1'b1;
      tick(); tick();
      ctrl_sel_inc = 1'b0;
      tick(); tick();
   endtask

   task automatic rand_ow();
      for (int w = 0; w < N*24/32; w++) ow_bus[w*32 +: 32] = $urandom();
      for (int w = 0; w < N2*24/32; w++) ow24[w*32 +: 32] = $urandom();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [N*18-1:0] tmp;
      rst_n = 1'b0;
      ctrl_sel_rst_n = 1'b1; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0;
      pad_clk = 1'b0; pad_rst_n = 1'b1; pad_ui_in = 8'h00; pad_uio_in = 8'h00;
      rand_ow();
      tick(); tick();
      rst_n = 1'b1;
      tick();
      chk("rst_ena", ena_bus, 0);
      chk("rst_addr", cur_addr, 0);
      chk("rst_active", sel_active, 0);

      // Enable from IDLE: one-hot on the third edge, project reset low for RC cycles.
      ctrl_ena = 1'b1;
      tick(); tick();
      chk("ena_e1", ena_bus, 0);
      tick();
      chk("ena_e2", ena_bus, 32'h1);
      chk("ena_active", sel_active, 1);
      chk("prst_low0", iw_bus[1], 0);
      for (int i = 1; i < RC; i++) begin
         tick();
         chk("prst_low", iw_bus[1], 0);
      end
      tick();
      chk("prst_follow", iw_bus[1], 1);
      ctrl_ena = 1'b0;
      repeat (8) tick();
      chk("idle_again", sel_active, 0);

      // Address 5 selected in IDLE, then data paths.
      repeat (5) inc_pulse();
      chk("addr5", cur_addr, 5);
      pad_ui_in = 8'hA5;
      ow_bus[5*24 +: 24] = 24'h3C817E;
      ctrl_ena = 1'b1;
      repeat (8) tick();
      chk("iw5_ui", iw_bus[5*18+2 +: 8], 8'hA5);
      chk("uo_out", pad_uo_out, 8'h7E);
      chk("uio_out", pad_uio_out, 8'h81);
      chk("uio_oe", pad_uio_oe, 8'h3C);
      tmp = iw_bus;
      tmp[5*18 +: 18] = '0;
      chk("iw_others", tmp, 0);
      chk("ena5", ena_bus, 32'h20);

      // Move to address 3 while active, then increment: guard of exactly GC cycles.
      ctrl_sel_rst_n = 1'b0;
      tick(); tick(); tick();
      ctrl_sel_rst_n = 1'b1;
      repeat (3) inc_pulse();
      repeat (10) tick();
      chk("run3", ena_bus, 32'h8);
      ctrl_sel_inc = 1'b1;
      for (int i = 0; i < 8 && ena_bus != 0; i++) tick();
      chk("guard_c1", ena_bus, 0);
      chk("guard_addr", cur_addr, 4);
      ctrl_sel_inc = 1'b0;
      tick();
      chk("guard_c2", ena_bus, 0);
      tick();
      chk("ena4", ena_bus, 32'h10);
      chk("prst4_low0", iw_bus[4*18+1], 0);
      for (int i = 1; i < RC; i++) begin
         tick();
         chk("prst4_low", iw_bus[4*18+1], 0);
      end
      tick();
      chk("prst4_follow", iw_bus[4*18+1], 1);

      // Wrap-around for both address ranges.
      ctrl_ena = 1'b0;
      repeat (6) tick();
      ctrl_sel_rst_n = 1'b0;
      tick(); tick(); tick();
      ctrl_sel_rst_n = 1'b1;
      repeat (23) inc_pulse();
      chk("addr23", cur_addr, 23);
      chk("addr24_23", addr24, 23);
      inc_pulse();
      chk("addr24", cur_addr, 24);
      chk("wrap24", addr24, 0);
      repeat (7) inc_pulse();
      chk("addr31", cur_addr, 31);
      inc_pulse();
      chk("wrap32", cur_addr, 0);

      // Clear dominates increment.
      inc_pulse();
      chk("addr1", cur_addr, 1);
      ctrl_sel_rst_n = 1'b0;
      ctrl_sel_inc   = 1'b1;
      repeat (4) tick();
      chk("clr_dom", cur_addr, 0);
      ctrl_sel_rst_n = 1'b1;
      ctrl_sel_inc   = 1'b0;
      repeat (3) tick();
      chk("clr_hold", cur_addr, 0);

      // Drop enable in the middle of RESET.
      ctrl_ena = 1'b1;
      for (int i = 0; i < 6 && !sel_active; i++) tick();
      chk("rst_enter", sel_active, 1);
      tick();
      ctrl_ena = 1'b0;
      repeat (6) tick();
      chk("drop_ena", ena_bus, 0);
      chk("drop_iw", iw_bus, 0);
      chk("drop_pad", {pad_uio_oe, pad_uio_out, pad_uo_out}, 0);
      chk("drop_active", sel_active, 0);

      // Randomized pad and control activity.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 7) == 0) ctrl_ena = ~ctrl_ena;
         if ($urandom_range(0, 5) == 0) ctrl_sel_inc = ~ctrl_sel_inc;
         if ($urandom_range(0, 19) == 0) ctrl_sel_rst_n = ~ctrl_sel_rst_n;
         else if (!ctrl_sel_rst_n && $urandom_range(0, 2) == 0) ctrl_sel_rst_n = 1'b1;
         pad_clk    = 1'($urandom());
         pad_rst_n  = ($urandom_range(0, 3) != 0);
         pad_ui_in  = 8'($urandom());
         pad_uio_in = 8'($urandom());
         if ($urandom_range(0, 3) == 0) rand_ow();
         tick();
      end

      // Asynchronous reset in the middle of RUN.
      ctrl_sel_rst_n = 1'b1; ctrl_sel_inc = 1'b0; ctrl_ena = 1'b0; pad_rst_n = 1'b1;
      repeat (6) tick();
      ctrl_sel_rst_n = 1'b0;
      tick(); tick(); tick();
      ctrl_sel_rst_n = 1'b1;
      inc_pulse(); inc_pulse();
      ctrl_ena = 1'b1;
      repeat (10) tick();
      chk("pre_arst_active", sel_active, 1);
      chk("pre_arst_addr", cur_addr, 2);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ena", ena_bus, 0);
      chk("arst_iw", iw_bus, 0);
      chk("arst_pad", {pad_uio_oe, pad_uio_out, pad_uo_out}, 0);
      chk("arst_addr", cur_addr, 0);
      chk("arst_active", sel_active, 0);
      check_model();
      @(negedge clk);
      rst_n = 1'b1;
      ctrl_ena = 1'b0;
      tick(); tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
